// File: rtl/dmac_memory_multi_cmd_queue_if.sv
// Bus bundle for the multi-channel DMA command queue: per-channel tail
// command inputs and status, plus the single arbitrated head port.
interface dmac_memory_multi_cmd_queue_if #(
  parameter int W_EXT_A         = 32,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int NUM_CH          = 4,
  parameter int W_CH            = 2
);

  logic [NUM_CH*W_EXT_A-1:0]         tail_ext_addr;
  logic [NUM_CH*W_EXT_A-1:0]         tail_core_addr;
  logic [NUM_CH-1:0]                 tail_read_enable;
  logic [NUM_CH-1:0]                 tail_write_enable;
  logic [NUM_CH*(W_EXT_A+1)-1:0]     tail_word_size;
  logic [NUM_CH-1:0]                 enq;
  logic [NUM_CH-1:0]                 full;
  logic [NUM_CH-1:0]                 almost_full;
  logic [NUM_CH*(FIFO_ADDR_WIDTH+1)-1:0] count;
  logic [NUM_CH-1:0]                 dropped;

  logic [W_EXT_A-1:0]                head_ext_addr;
  logic [W_EXT_A-1:0]                head_core_addr;
  logic                              head_read_enable;
  logic                              head_write_enable;
  logic [W_EXT_A:0]                  head_word_size;
  logic [W_CH-1:0]                   head_channel;
  logic                              head_valid;
  logic                              head_ready;
  logic                              empty_all;

  // Queue side: consumes tail commands and the head ready, drives status/head.
  modport slave (
    input  tail_ext_addr, tail_core_addr, tail_read_enable, tail_write_enable,
           tail_word_size, enq, head_ready,
    output full, almost_full, count, dropped,
           head_ext_addr, head_core_addr, head_read_enable, head_write_enable,
           head_word_size, head_channel, head_valid, empty_all
  );

  // Environment side: producers on the tail, DMA engine on the head.
  modport master (
    output tail_ext_addr, tail_core_addr, tail_read_enable, tail_write_enable,
           tail_word_size, enq, head_ready,
    input  full, almost_full, count, dropped,
           head_ext_addr, head_core_addr, head_read_enable, head_write_enable,
           head_word_size, head_channel, head_valid, empty_all
  );

endinterface

// File: rtl/dmac_memory_multi_cmd_queue.sv
// Multi-channel DMA command queue: NUM_CH first-word-fall-through FIFOs
// feeding a round-robin arbiter that presents one command at a time to the
// memory-side DMA engine.
module dmac_memory_multi_cmd_queue #(
  parameter int W_EXT_A            = 32,
  parameter int FIFO_ADDR_WIDTH    = 4,
  parameter int NUM_CH             = 4,
  parameter int W_CH               = 2,
  parameter int ALMOST_FULL_MARGIN = 2,
  parameter int DROP_ZERO          = 1
) (
  input logic clk,
  input logic rst,
  dmac_memory_multi_cmd_queue_if.slave bus
);

  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 2**AW;
  localparam int WS_W  = W_EXT_A + 1;
  localparam int AF_TH = DEPTH - ALMOST_FULL_MARGIN;
  // A non-positive threshold collapses to 0 so almost_full is always set.
  localparam logic [AW:0] AF_TH_V = (AF_TH <= 0) ? '0 : (AW+1)'(AF_TH);

  typedef struct packed {
    logic [W_EXT_A-1:0] ext_addr;
    logic [W_EXT_A-1:0] core_addr;
    logic               rd;
    logic               wr;
    logic [WS_W-1:0]    word_size;
  } cmd_t;

  cmd_t              tail_cmd [NUM_CH];
  cmd_t              mem      [NUM_CH][DEPTH];
  logic [AW:0]       wr_ptr   [NUM_CH];
  logic [AW:0]       rd_ptr   [NUM_CH];
  logic [AW:0]       cnt      [NUM_CH];

  logic [NUM_CH-1:0] full_w;
  logic [NUM_CH-1:0] af_w;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] zero_len;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] store;
  logic [NUM_CH-1:0] deq;
  logic [NUM_CH-1:0] dropped_q;

  logic [W_CH-1:0]   rr_ptr;
  logic [W_CH-1:0]   gnt;
  logic [W_CH-1:0]   next_rr;
  logic [W_CH-1:0]   scan_idx;
  logic              any_valid;
  cmd_t              head_cmd;

  logic [NUM_CH*(AW+1)-1:0] count_v;

  // Unpack tail buses and derive per-channel status from registered pointers.
  always_comb begin
    count_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tail_cmd[i].ext_addr  = bus.tail_ext_addr[i*W_EXT_A +: W_EXT_A];
      tail_cmd[i].core_addr = bus.tail_core_addr[i*W_EXT_A +: W_EXT_A];
      tail_cmd[i].rd        = bus.tail_read_enable[i];
      tail_cmd[i].wr        = bus.tail_write_enable[i];
      tail_cmd[i].word_size = bus.tail_word_size[i*WS_W +: WS_W];

      cnt[i]      = wr_ptr[i] - rd_ptr[i];
      full_w[i]   = (wr_ptr[i] == {~rd_ptr[i][AW], rd_ptr[i][AW-1:0]});
      nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
      af_w[i]     = (cnt[i] >= AF_TH_V);
      zero_len[i] = (tail_cmd[i].word_size == '0);
      accept[i]   = bus.enq[i] && !full_w[i];
      store[i]    = accept[i] && !((DROP_ZERO != 0) && zero_len[i]);
      count_v[i*(AW+1) +: AW+1] = cnt[i];
    end
  end

  // Round-robin grant: first nonempty channel scanning from rr_ptr upward.
  always_comb begin
    gnt       = rr_ptr;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = W_CH'((int'(rr_ptr) + k) % NUM_CH);
      if (!any_valid && nonempty[scan_idx]) begin
        any_valid = 1'b1;
        gnt       = scan_idx;
      end
    end
    next_rr = W_CH'((int'(gnt) + 1) % NUM_CH);
    deq = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      deq[i] = any_valid && bus.head_ready && (gnt == W_CH'(i));
    end
  end

  // Head presents the granted channel's oldest entry (fall-through read).
  always_comb begin
    head_cmd = mem[gnt][rd_ptr[gnt][AW-1:0]];
  end

  // Pointer, arbitration and drop-pulse state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      dropped_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (store[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      dropped_q <= accept & zero_len & {NUM_CH{DROP_ZERO != 0}};
      if (any_valid && bus.head_ready) rr_ptr <= next_rr;
    end
  end

  // Command storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (store[i]) mem[i][wr_ptr[i][AW-1:0]] <= tail_cmd[i];
    end
  end

  assign bus.full              = full_w;
  assign bus.almost_full       = af_w;
  assign bus.count             = count_v;
  assign bus.dropped           = dropped_q;
  assign bus.head_ext_addr     = head_cmd.ext_addr;
  assign bus.head_core_addr    = head_cmd.core_addr;
  assign bus.head_read_enable  = head_cmd.rd;
  assign bus.head_write_enable = head_cmd.wr;
  assign bus.head_word_size    = head_cmd.word_size;
  assign bus.head_channel      = gnt;
  assign bus.head_valid        = any_valid;
  assign bus.empty_all         = ~any_valid;

endmodule

// File: tb/tb_dmac_memory_multi_cmd_queue.sv
// Directed bench for the multi-channel DMA command queue.
module tb_dmac_memory_multi_cmd_queue;

  localparam int WA = 32;
  localparam int AW = 4;
  localparam int NC = 4;
  localparam int WC = 2;
  localparam int WS = WA + 1;
  localparam int CW = AW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  dmac_memory_multi_cmd_queue_if #(.W_EXT_A(WA), .FIFO_ADDR_WIDTH(AW),
                                   .NUM_CH(NC), .W_CH(WC)) bus ();

  dmac_memory_multi_cmd_queue #(
    .W_EXT_A(WA), .FIFO_ADDR_WIDTH(AW), .NUM_CH(NC), .W_CH(WC),
    .ALMOST_FULL_MARGIN(2), .DROP_ZERO(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int ch, input logic [WA-1:0] ext, input logic [WA-1:0] core,
                         input logic rd, input logic wr, input logic [WS-1:0] ws);
    bus.tail_ext_addr[ch*WA +: WA]  = ext;
    bus.tail_core_addr[ch*WA +: WA] = core;
    bus.tail_read_enable[ch]        = rd;
    bus.tail_write_enable[ch]       = wr;
    bus.tail_word_size[ch*WS +: WS] = ws;
  endtask

  initial begin
    bus.tail_ext_addr     = '0;
    bus.tail_core_addr    = '0;
    bus.tail_read_enable  = '0;
    bus.tail_write_enable = '0;
    bus.tail_word_size    = '0;
    bus.enq               = '0;
    bus.head_ready        = 1'b0;

    // Reset applied mid-cycle takes effect immediately.
    #2 rst = 1'b1;
    #1;
    chk("rst_head_valid", bus.head_valid, 0);
    chk("rst_empty_all", bus.empty_all, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_almost_full", bus.almost_full, 0);
    chk("rst_dropped", bus.dropped, 0);
    chk("rst_head_channel", bus.head_channel, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill channel 2 to capacity with the head stalled.
    for (int k = 0; k < 16; k++) begin
      set_cmd(2, 32'h1000 + k, k, 1'b1, 1'b0, k + 1);
      bus.enq = 4'b0100;
      tick();
      chk("fill_count", bus.count[2*CW +: CW], k + 1);
      chk("fill_almost_full", bus.almost_full[2], (k + 1 >= 14) ? 1 : 0);
      chk("fill_full", bus.full[2], (k + 1 == 16) ? 1 : 0);
    end
    chk("fill_head_channel", bus.head_channel, 2);
    set_cmd(2, 32'hDEAD, 99, 1'b0, 1'b0, 7);
    tick();
    bus.enq = '0;
    chk("overfill_count", bus.count[2*CW +: CW], 16);
    chk("overfill_full", bus.full[2], 1);

    bus.head_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", bus.head_valid, 1);
      chk("drain_channel", bus.head_channel, 2);
      chk("drain_core", bus.head_core_addr, k);
      chk("drain_ext", bus.head_ext_addr, 32'h1000 + k);
      chk("drain_ws", bus.head_word_size, k + 1);
      tick();
    end
    bus.head_ready = 1'b0;
    chk("drain_empty_valid", bus.head_valid, 0);
    chk("drain_empty_all", bus.empty_all, 1);

    // Reset so the round-robin pointer starts at channel 0.
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Load all four channels simultaneously, three commands each.
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NC; c++) set_cmd(c, 32'h0, c*16 + k, 1'b1, 1'b0, 4);
      bus.enq = 4'b1111;
      tick();
    end
    bus.enq = '0;
    chk("rr_load_count", bus.count, {5'd3, 5'd3, 5'd3, 5'd3});
    bus.head_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      chk("rr_channel", bus.head_channel, j % 4);
      chk("rr_core", bus.head_core_addr, (j % 4)*16 + j/4);
      tick();
    end
    bus.head_ready = 1'b0;
    chk("rr_done_valid", bus.head_valid, 0);

    // Zero-length command is dropped with a one-cycle pulse.
    set_cmd(1, 32'h77, 32'h11, 1'b1, 1'b0, 0);
    bus.enq = 4'b0010;
    tick();
    bus.enq = '0;
    chk("zero_dropped", bus.dropped, 4'b0010);
    chk("zero_count", bus.count[1*CW +: CW], 0);
    chk("zero_valid", bus.head_valid, 0);
    tick();
    chk("zero_dropped_clear", bus.dropped, 0);
    set_cmd(1, 32'h88, 32'h55, 1'b1, 1'b1, 5);
    bus.enq = 4'b0010;
    tick();
    bus.enq = '0;
    chk("ws5_valid", bus.head_valid, 1);
    chk("ws5_channel", bus.head_channel, 1);
    chk("ws5_ws", bus.head_word_size, 5);
    chk("ws5_core", bus.head_core_addr, 32'h55);
    chk("ws5_rdwr", {bus.head_read_enable, bus.head_write_enable}, 2'b11);
    chk("ws5_count", bus.count[1*CW +: CW], 1);
    chk("ws5_no_drop", bus.dropped, 0);
    bus.head_ready = 1'b1;
    tick();
    bus.head_ready = 1'b0;
    chk("ws5_drained", bus.head_valid, 0);

    // Full channel 0: enqueue rejected while dequeue proceeds.
    for (int k = 0; k < 16; k++) begin
      set_cmd(0, 32'h0, 32'h200 + k, 1'b0, 1'b1, 2);
      bus.enq = 4'b0001;
      tick();
    end
    chk("ch0_full", bus.full[0], 1);
    set_cmd(0, 32'h0, 32'h2FF, 1'b0, 1'b1, 2);
    bus.head_ready = 1'b1;
    chk("ch0_grant", bus.head_channel, 0);
    tick();
    chk("fulldeq_count", bus.count[0*CW +: CW], 15);
    chk("fulldeq_full", bus.full[0], 0);
    chk("fulldeq_head", bus.head_core_addr, 32'h201);
    set_cmd(0, 32'h0, 32'h2AA, 1'b0, 1'b1, 2);
    tick();
    bus.enq = '0;
    bus.head_ready = 1'b0;
    chk("simul_count", bus.count[0*CW +: CW], 15);
    chk("simul_head", bus.head_core_addr, 32'h202);

    // Reset mid-operation discards queued commands.
    for (int k = 0; k < 5; k++) begin
      set_cmd(3, 32'h0, 32'h300 + k, 1'b1, 1'b0, 3);
      bus.enq = 4'b1000;
      tick();
    end
    bus.enq = '0;
    chk("ch3_count", bus.count[3*CW +: CW], 5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_count3", bus.count[3*CW +: CW], 0);
    chk("midrst_count_all", bus.count, 0);
    chk("midrst_valid", bus.head_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    set_cmd(3, 32'hABCD, 32'h333, 1'b0, 1'b1, 7);
    bus.enq = 4'b1000;
    chk("post_rst_before", bus.head_valid, 0);
    tick();
    bus.enq = '0;
    chk("post_rst_valid", bus.head_valid, 1);
    chk("post_rst_channel", bus.head_channel, 3);
    chk("post_rst_core", bus.head_core_addr, 32'h333);
    chk("post_rst_ext", bus.head_ext_addr, 32'hABCD);
    chk("post_rst_ws", bus.head_word_size, 7);
    chk("post_rst_rdwr", {bus.head_read_enable, bus.head_write_enable}, 2'b01);
    chk("post_rst_count", bus.count[3*CW +: CW], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmac_memory_multi_cmd_queue.md
Name: dmac_memory_multi_cmd_queue

Overview:
Multi-channel DMA command queue. NUM_CH independent single-clock command FIFOs, one per requesting core-side channel, sit in front of a round-robin arbiter that presents one command at a time to the memory-side DMA engine over a valid/ready head interface. Each channel reports its occupancy count, a parametrised almost-full threshold, and optional zero-length command filtering.

Parameters:
W_EXT_A, 32, address width; word_size field is W_EXT_A+1 bits
FIFO_ADDR_WIDTH, 4, per-channel depth DEPTH = 2**FIFO_ADDR_WIDTH entries (full capacity usable)
NUM_CH, 4, number of tail channels (1..16)
W_CH, 2, width of head_channel; must satisfy 2**W_CH >= NUM_CH
ALMOST_FULL_MARGIN, 2, almost_full asserted when count >= DEPTH-ALMOST_FULL_MARGIN
DROP_ZERO, 1, 1 = accepted commands with word_size==0 are discarded, not stored

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
tail_ext_addr  in  NUM_CH*W_EXT_A  per-channel byte address, channel i at [i*W_EXT_A +: W_EXT_A]
tail_core_addr  in  NUM_CH*W_EXT_A  per-channel word address
tail_read_enable  in  NUM_CH  per-channel read command flag
tail_write_enable  in  NUM_CH  per-channel write command flag
tail_word_size  in  NUM_CH*(W_EXT_A+1)  per-channel word count
enq  in  NUM_CH  per-channel enqueue request
full  out  NUM_CH  channel i holds DEPTH entries
almost_full  out  NUM_CH  channel i count >= DEPTH-ALMOST_FULL_MARGIN
count  out  NUM_CH*(FIFO_ADDR_WIDTH+1)  per-channel occupancy
dropped  out  NUM_CH  one-cycle pulse: zero-length command discarded
head_ext_addr  out  W_EXT_A  granted command byte address
head_core_addr  out  W_EXT_A  granted command word address
head_read_enable  out  1  granted command read flag
head_write_enable  out  1  granted command write flag
head_word_size  out  W_EXT_A+1  granted command word count
head_channel  out  W_CH  index of granted channel
head_valid  out  1  a command is presented
head_ready  in  1  consumer accepts presented command
empty_all  out  1  all channels empty

Behaviour:
- Reset (async, rst=1): all pointers, counts and rr_ptr = 0; full=0, almost_full=0 (or 1 if DEPTH-ALMOST_FULL_MARGIN<=0), dropped=0, count=0, head_valid=0, empty_all=1, head_channel=0; head data don't-care. RAM contents not cleared. Reset mid-operation discards all queued commands; first legal enq after deassertion accepted.
- Storage: per-channel register array, read pointer/write pointer FIFO_ADDR_WIDTH+1 bits (extra wrap bit); full = pointers equal except MSB. Pointers wrap DEPTH-1 -> 0.
- Enqueue: accepted when enq[i] && !full[i] (full as registered at cycle start). Accepted entry written at edge; count[i], full, almost_full, empty_all reflect it next cycle. Enq while full ignored, no state change.
- DROP_ZERO=1 and accepted command has word_size==0: not stored, count unchanged, dropped[i]=1 for exactly the following cycle. DROP_ZERO=0: stored like any command.
- Head (first-word-fall-through): head_valid = any channel nonempty. Grant combinational from registered state: first nonempty channel scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH. head_* fields = that channel's oldest entry; head_channel = its index.
- Handshake: head_valid && head_ready dequeues granted channel at edge; rr_ptr <= (granted+1) mod NUM_CH. No handshake: rr_ptr holds, grant stable while no new channel earlier in scan order becomes nonempty. head_ready with head_valid=0 has no effect.
- Enq-to-head latency: command enqueued to empty queue at edge N is presentable from cycle N+1.
- Simultaneous enq and dequeue on same channel: both take effect; count unchanged. If channel was full, enq rejected, dequeue proceeds, count = DEPTH-1.
- Simultaneous enq on multiple channels: all independent, all accepted if not full.
- Fairness: with all channels continuously nonempty and head_ready=1, grants rotate 0,1,..,NUM_CH-1,0,...
- Commands with both read and write enable set are stored and forwarded unmodified.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> immediately head_valid=0, empty_all=1, count all 0, full=0.
- Fill channel 2 (DEPTH=16) with head_ready=0: 16 enqs -> count[2]=16, full[2]=1 after 16th, almost_full[2]=1 from count 14; 17th enq ignored; drain yields core_addr 0..15 in order.
- Round-robin: channels 0..3 each loaded with 3 commands, head_ready=1 -> head_channel sequence 0,1,2,3,0,1,2,3,0,1,2,3, then head_valid=0.
- Zero-length: DROP_ZERO=1, enq word_size=0 on ch1 -> dropped[1]=1 one cycle, count[1]=0, head_valid stays 0; word_size=5 next -> stored and presented.
- Full + simultaneous enq/deq on ch0: enq and handshake same cycle -> enq rejected, count[0]=15; not full: count unchanged.
- Reset mid-operation: 5 entries on ch3 then rst -> count[3]=0, head_valid=0; new enq after release presented at N+1 with correct fields.
